// File: rtl/tof_arb_pkg.sv
// Shared definitions for the ToF readout arbiter.
//   tof_state_e : arbiter FSM states (IDLE waits for a grant, PRESENT holds a word)
//   TOF_DATA_W  : captured word width {zone_index[5:0], distance[15:0]}
//   TOF_IDX_W   : sensor index width, sized for up to 8 sensors
//   TOF_TS_W    : capture timestamp width (only used with TOF_ARB_TIMESTAMP_EN)
package tof_arb_pkg;

  localparam int TOF_DATA_W = 22;
  localparam int TOF_IDX_W  = 3;
  localparam int TOF_TS_W   = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } tof_state_e;

endpackage

// File: rtl/tof_rr_picker.sv
// Combinational round-robin find-first.
// Searches req upward starting at last_grant+1 and wrapping modulo N; the
// first set bit found is the grant.
//   req        in  N      request vector (one bit per sensor)
//   last_grant in  IDX_W  index granted most recently
//   grant      out IDX_W  selected index (0 when no request)
//   any_req    out 1      at least one request bit is set
module tof_rr_picker
  import tof_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = TOF_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Offset k runs 1..N so last_grant itself is examined last, which gives
  // every other requester priority over the most recent winner.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/tof_readout_arbiter.sv
// Shares one downstream readout channel between NB_OF_SENSORS ToF FSMs.
// Each data_ready pulse captures the sensor's word into a holding register
// and marks it pending; pending words are granted round-robin and presented
// on a valid/ready output, with a one-cycle ack to the owning sensor.
//
// Handshake: out_valid rises with a granted word and out_sensor/out_data
// (and out_timestamp) stay stable while out_valid=1; a transfer happens on a
// rising clk edge where out_valid && out_ready, after which out_valid drops
// for one cycle (IDLE) and ack[out_sensor] pulses for exactly that cycle.
//
// Optional feature macro: TOF_ARB_TIMESTAMP_EN adds a 16-bit free-running
// counter, per-sensor capture timestamps and the out_timestamp port.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   enable        in   0 blocks new grants (capture continues)
//   data_ready    in   N  one-cycle capture pulse per sensor
//   sensor_data   in   N*DATA_W flat bus, sensor i at [i*DATA_W +: DATA_W]
//   out_valid     out  word valid
//   out_ready     in   downstream accepts the word
//   out_sensor    out  IDX_W owner of out_data
//   out_data      out  DATA_W granted word
//   out_timestamp out  16 capture time of out_data (macro only)
//   ack           out  N  pulse the cycle after a transfer
//   pending       out  N  holding register holds an unsent word
//   overrun       out  N  sticky: an unsent word was overwritten
//   overrun_clr   in   synchronous clear of all overrun bits
//   dbg_state     out  current FSM state
module tof_readout_arbiter
  import tof_arb_pkg::*;
#(
  parameter int NB_OF_SENSORS = 8,
  parameter int DATA_W        = TOF_DATA_W,
  parameter int IDX_W         = TOF_IDX_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NB_OF_SENSORS-1:0]        data_ready,
  input  logic [NB_OF_SENSORS*DATA_W-1:0] sensor_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_W-1:0]                out_sensor,
  output logic [DATA_W-1:0]               out_data,
`ifdef TOF_ARB_TIMESTAMP_EN
  output logic [TOF_TS_W-1:0]             out_timestamp,
`endif
  output logic [NB_OF_SENSORS-1:0]        ack,
  output logic [NB_OF_SENSORS-1:0]        pending,
  output logic [NB_OF_SENSORS-1:0]        overrun,
  input  logic                            overrun_clr,
  output tof_state_e                      dbg_state
);

  tof_state_e               state_q, state_d;
  logic [IDX_W-1:0]         last_grant_q;
  logic [IDX_W-1:0]         grant;
  logic                     any_req;
  logic                     grant_fire;
  logic                     handshake;
  logic [NB_OF_SENSORS-1:0] grant_vec;

  logic [DATA_W-1:0]        hold_q [NB_OF_SENSORS];
  logic [NB_OF_SENSORS-1:0] pending_q, pending_d;
  logic [NB_OF_SENSORS-1:0] overrun_q, overrun_d;
  logic [NB_OF_SENSORS-1:0] ack_q;
  logic                     out_valid_q;
  logic [IDX_W-1:0]         out_sensor_q;
  logic [DATA_W-1:0]        out_data_q;

  tof_rr_picker #(
    .N     (NB_OF_SENSORS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (pending_q),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_req    (any_req)
  );

  // FSM next state and the two events that drive the datapath.
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    handshake  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          grant_fire = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (out_valid_q && out_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture bookkeeping. A capture on the grant edge of the same sensor
  // refills the register that is being emptied, so it is neither an
  // overrun nor a reason to clear pending. A new overrun beats the clear.
  always_comb begin
    grant_vec = '0;
    if (grant_fire) grant_vec = NB_OF_SENSORS'(1) << grant;
    pending_d = pending_q;
    overrun_d = overrun_clr ? '0 : overrun_q;
    for (int i = 0; i < NB_OF_SENSORS; i++) begin
      if (data_ready[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i] && !grant_vec[i]) overrun_d[i] = 1'b1;
      end else if (grant_vec[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      overrun_q <= '0;
      for (int i = 0; i < NB_OF_SENSORS; i++) hold_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NB_OF_SENSORS; i++) begin
        if (data_ready[i]) hold_q[i] <= sensor_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register: loaded only on a grant, so it stays frozen through
  // PRESENT regardless of new captures into hold_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_sensor_q <= '0;
      out_data_q   <= '0;
      last_grant_q <= IDX_W'(NB_OF_SENSORS - 1);
      ack_q        <= '0;
    end else begin
      ack_q <= '0;
      if (grant_fire) begin
        out_valid_q  <= 1'b1;
        out_sensor_q <= grant;
        out_data_q   <= hold_q[grant];
      end else if (handshake) begin
        out_valid_q  <= 1'b0;
        last_grant_q <= out_sensor_q;
        ack_q        <= NB_OF_SENSORS'(1) << out_sensor_q;
      end
    end
  end

`ifdef TOF_ARB_TIMESTAMP_EN
  logic [TOF_TS_W-1:0] ts_cnt_q;
  logic [TOF_TS_W-1:0] ts_q [NB_OF_SENSORS];
  logic [TOF_TS_W-1:0] out_ts_q;

  // Free-running counter; wraps 0xFFFF -> 0 by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt_q <= '0;
      out_ts_q <= '0;
      for (int i = 0; i < NB_OF_SENSORS; i++) ts_q[i] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      for (int i = 0; i < NB_OF_SENSORS; i++) begin
        if (data_ready[i]) ts_q[i] <= ts_cnt_q;
      end
      if (grant_fire) out_ts_q <= ts_q[grant];
    end
  end

  assign out_timestamp = out_ts_q;
`endif

  assign out_valid  = out_valid_q;
  assign out_sensor = out_sensor_q;
  assign out_data   = out_data_q;
  assign ack        = ack_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tof_readout_arbiter.sv
// Directed testbench for tof_readout_arbiter (8 sensors, 22-bit words).
// Expected words {timestamp, sensor, data} are queued when stimulus is driven
// and checked when a transfer is seen on the output; ack is checked every
// cycle against the owner of the previous transfer.
module tb_tof_readout_arbiter;
  import tof_arb_pkg::*;

  localparam int N  = 8;
  localparam int DW = 22;
  localparam int EW = 16 + 3 + DW;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [N-1:0]    data_ready;
  logic [N*DW-1:0] sensor_data;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_sensor;
  logic [DW-1:0]   out_data;
  logic [15:0]     out_timestamp;
  logic [N-1:0]    ack;
  logic [N-1:0]    pending;
  logic [N-1:0]    overrun;
  logic            overrun_clr;
  tof_state_e      dbg_state;

  logic [EW-1:0]   exp_q[$];
  logic [N-1:0]    exp_ack;
  logic [15:0]     tb_cnt;
  int              n_assert;
  int              n_fail;

  tof_readout_arbiter #(.NB_OF_SENSORS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .data_ready  (data_ready),
    .sensor_data (sensor_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sensor  (out_sensor),
    .out_data    (out_data),
`ifdef TOF_ARB_TIMESTAMP_EN
    .out_timestamp (out_timestamp),
`endif
    .ack         (ack),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .dbg_state   (dbg_state)
  );

`ifndef TOF_ARB_TIMESTAMP_EN
  assign out_timestamp = '0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time base: edges counted since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 16'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no_finish required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int s, input logic [DW-1:0] d, input logic [15:0] ts);
    exp_q.push_back({ts, 3'(s), d});
  endfunction

  // Scoreboard: pop on every transfer, check ack one cycle later.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      exp_ack = '0;
    end else begin
      check("ack", 64'(ack), 64'(exp_ack));
      exp_ack = '0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_sensor", 64'(out_sensor), 64'(e[DW+2:DW]));
          check("out_data", 64'(out_data), 64'(e[DW-1:0]));
`ifdef TOF_ARB_TIMESTAMP_EN
          check("out_timestamp", 64'(out_timestamp), 64'(e[EW-1:DW+3]));
`endif
          exp_ack = N'(1) << e[DW+2:DW];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulses data_ready=mask for one cycle; sensor i gets base + i*step.
  // When push is set, words are queued in grant order starting at 'start'.
  task automatic pulse(input logic [N-1:0] mask, input logic [DW-1:0] base,
                       input int step, input int start, input bit push);
    for (int i = 0; i < N; i++)
      if (mask[i]) sensor_data[i*DW +: DW] = base + DW'(i * step);
    data_ready = mask;
    if (push) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (start + k) % N;
        if (mask[j]) push_exp(j, base + DW'(j * step), tb_cnt);
      end
    end
    @(posedge clk); #1;
    data_ready = '0;
  endtask

  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_valid", 64'(out_valid), 64'(1));
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("drain_valid", 64'(out_valid), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert    = 0;
    n_fail      = 0;
    exp_ack     = '0;
    reset       = 1'b0;
    enable      = 1'b1;
    data_ready  = '0;
    sensor_data = '0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;

    // Reset state.
    #22;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_out_sensor", 64'(out_sensor), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    reset = 1'b1;
    step_cycles(2);

    // Round robin: all eight in one cycle, sensor 0 first, one every 2 cycles.
    out_ready = 1'b1;
    pulse(8'hFF, 22'h000010, 1, 0, 1'b1);
    step_cycles(15);
    check("rr_queue_left_1", 64'(exp_q.size()), 64'(1));
    step_cycles(1);
    check("rr_queue_empty", 64'(exp_q.size()), 64'(0));
    step_cycles(2);
    check("rr_pending", 64'(pending), 64'(0));
    check("rr_out_valid", 64'(out_valid), 64'(0));

    // Single request, 2-cycle latency.
    pulse(8'h08, 22'h15A5A5, 0, 3, 1'b1);
    check("lat_valid_early", 64'(out_valid), 64'(0));
    step_cycles(1);
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_sensor", 64'(out_sensor), 64'(3));
    check("lat_data", 64'(out_data), 64'(22'h15A5A5));
    drain(10);
    check("single_pending3", 64'(pending[3]), 64'(0));

    // Fairness after wrap: last_grant=5, then 1 and 6 together -> 6 first.
    pulse(8'h20, 22'h005005, 0, 5, 1'b1);
    drain(10);
    pulse(8'h42, 22'h002000, 22'h100, 6, 1'b1);
    wait_valid(5);
    check("fair_first", 64'(out_sensor), 64'(6));
    drain(10);

    // Backpressure and overwrite on sensor 2.
    out_ready = 1'b0;
    pulse(8'h04, 22'h000100, 0, 2, 1'b1);
    wait_valid(5);
    pulse(8'h04, 22'h000200, 0, 2, 1'b0);
    check("bp_data_hold", 64'(out_data), 64'(22'h000100));
    check("bp_pending2", 64'(pending[2]), 64'(1));
    check("bp_no_overrun", 64'(overrun[2]), 64'(0));
    pulse(8'h04, 22'h000300, 0, 2, 1'b1);
    check("bp_overrun2", 64'(overrun[2]), 64'(1));
    check("bp_data_hold2", 64'(out_data), 64'(22'h000100));
    out_ready = 1'b1;
    drain(10);

    // overrun_clr.
    overrun_clr = 1'b1;
    step_cycles(1);
    overrun_clr = 1'b0;
    check("ovr_clear", 64'(overrun), 64'(0));

    // Set beats clear, then reset in the middle of PRESENT.
    out_ready = 1'b0;
    pulse(8'h22, 22'h000500, 22'h1000, 3, 1'b0);
    wait_valid(5);
    check("pre_rst_sensor", 64'(out_sensor), 64'(5));
    check("pre_rst_pending", 64'(pending), 64'(8'h02));
    overrun_clr = 1'b1;
    pulse(8'h02, 22'h000777, 0, 1, 1'b0);
    overrun_clr = 1'b0;
    check("ovr_set_beats_clr", 64'(overrun), 64'(8'h02));
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_pending", 64'(pending), 64'(0));
    check("mid_rst_ack", 64'(ack), 64'(0));
    check("mid_rst_overrun", 64'(overrun), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    pulse(8'h09, 22'h0000A0, 22'h10, 0, 1'b1);
    wait_valid(5);
    check("post_rst_first", 64'(out_sensor), 64'(0));
    drain(10);

    // enable low blocks grants; word in flight still completes.
    enable = 1'b0;
    pulse(8'h10, 22'h004444, 0, 4, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("en_blocked", 64'(out_valid), 64'(0));
      step_cycles(1);
    end
    check("en_pending", 64'(pending), 64'(8'h10));
    enable = 1'b1;
    wait_valid(5);
    check("en_grant", 64'(out_sensor), 64'(4));
    enable = 1'b0;
    drain(10);
    enable = 1'b1;
    step_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
